// File: rtl/lcd_capture_pkg.sv
// Shared types and helpers for the LCD segment capture block.
//   NUM_COMMONS  number of common strobes / frame rows
//   ROW_W        width of one captured row: {bs, b[15:0], a[15:0]}
//   seg_row_t    one captured row
//   cap_state_t  capture FSM states
//   is_onehot / onehot_to_index  common strobe decoding
package lcd_capture_pkg;

   localparam int NUM_COMMONS = 4;
   localparam int ROW_W       = 33;
   localparam int ROW_IDX_W   = $clog2(NUM_COMMONS);

   typedef logic [ROW_W-1:0] seg_row_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      RELEASE = 2'd3
   } cap_state_t;

   function automatic logic is_onehot(input logic [NUM_COMMONS-1:0] h);
      return ($countones(h) == 1);
   endfunction

   // Only meaningful for a one-hot input; the highest set bit wins otherwise.
   function automatic logic [ROW_IDX_W-1:0] onehot_to_index(input logic [NUM_COMMONS-1:0] h);
      logic [ROW_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_COMMONS; i++) begin
         if (h[i]) idx = ROW_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/lcd_row_bank.sv
// Double-buffered row storage: 2 banks x NUM_COMMONS rows x ROW_W bits.
//   clk, reset_n        clock, synchronous active-low reset (clears all rows and rd_data)
//   wr_en/wr_bank/wr_row/wr_data   single write port
//   rd_bank/rd_row      registered read address, 1 clk latency
//   rd_clear            forces the registered read data to zero instead of reading
//   rd_data             registered read data
module lcd_row_bank
   import lcd_capture_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 wr_en,
   input  logic                 wr_bank,
   input  logic [ROW_IDX_W-1:0] wr_row,
   input  logic [ROW_W-1:0]     wr_data,
   input  logic                 rd_bank,
   input  logic [ROW_IDX_W-1:0] rd_row,
   input  logic                 rd_clear,
   output logic [ROW_W-1:0]     rd_data
);

   seg_row_t mem [0:1][0:NUM_COMMONS-1];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < NUM_COMMONS; r++) begin
               mem[b][r] <= '0;
            end
         end
         rd_data <= '0;
      end else begin
         if (wr_en) mem[wr_bank][wr_row] <= wr_data;
         // The read samples the bank before any same-edge write or bank swap
         // in the parent takes effect, so a swap-cycle read sees the old front.
         if (rd_clear) rd_data <= '0;
         else          rd_data <= mem[rd_bank][rd_row];
      end
   end

endmodule

// File: rtl/lcd_segment_capture.sv
// Rebuilds the SM510 LCD segment frame from the multiplexed common strobes.
// A one-hot common must be stable for SETTLE_TICKS clk_en ticks, then the
// segment lines are captured into the back bank row for that common. When all
// rows have been seen the banks swap on the following clk.
//   clk, reset_n   clock, synchronous active-low reset
//   clk_en         32.768kHz tick shared with the core
//   output_h       common strobes (bit i = common i)
//   segment_a/b/bs segment lines
//   rd_addr        front-bank row to read
//   rd_data        {bs, b, a} of front-bank row rd_addr, 1 clk latency, 0 while inactive
//   frame_done     one-clk pulse on bank swap
//   frame_count    completed frames, wraps 255->0
//   lcd_active     1 while captures keep arriving within TIMEOUT_TICKS
module lcd_segment_capture
   import lcd_capture_pkg::*;
#(
   parameter int SETTLE_TICKS  = 2,
   parameter int TIMEOUT_TICKS = 2048
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk_en,
   input  logic [3:0]  output_h,
   input  logic [15:0] segment_a,
   input  logic [15:0] segment_b,
   input  logic        segment_bs,
   input  logic [1:0]  rd_addr,
   output logic [32:0] rd_data,
   output logic        frame_done,
   output logic [7:0]  frame_count,
   output logic        lcd_active
);

   localparam int SETTLE_W = $clog2(SETTLE_TICKS + 1);
   localparam int TMO_W    = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_TICKS - 1);
   localparam logic [TMO_W-1:0]    TMO_MAX     = TMO_W'(TIMEOUT_TICKS);
   localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT_TICKS - 1);

   cap_state_t                 state, state_nx;
   logic [NUM_COMMONS-1:0]     h_sel, h_sel_nx;
   logic [SETTLE_W-1:0]        settle_cnt, settle_cnt_nx;
   logic                       capture;

   logic [NUM_COMMONS-1:0]     seen;
   logic [NUM_COMMONS-1:0]     seen_cap;
   logic                       front;
   logic                       swap_pend;
   logic [TMO_W-1:0]           tmo_cnt;
   logic                       cap_tick;
   logic [ROW_IDX_W-1:0]       cap_idx;

   // Next-state logic; only committed on clk_en ticks.
   always_comb begin
      state_nx      = state;
      h_sel_nx      = h_sel;
      settle_cnt_nx = settle_cnt;
      capture       = 1'b0;
      case (state)
         IDLE: begin
            if (is_onehot(output_h)) begin
               h_sel_nx      = output_h;
               settle_cnt_nx = '0;
               state_nx      = SETTLE;
            end
         end
         SETTLE: begin
            if (output_h != h_sel) begin
               // A different one-hot value restarts settling on that common.
               if (is_onehot(output_h)) begin
                  h_sel_nx      = output_h;
                  settle_cnt_nx = '0;
               end else begin
                  state_nx = IDLE;
               end
            end else if (settle_cnt == SETTLE_LAST) begin
               state_nx = CAPTURE;
            end else begin
               settle_cnt_nx = settle_cnt + SETTLE_W'(1);
            end
         end
         CAPTURE: begin
            capture  = 1'b1;
            state_nx = RELEASE;
         end
         RELEASE: begin
            // Leaving the common is evaluated exactly like IDLE on the same tick.
            if (output_h != h_sel) begin
               if (is_onehot(output_h)) begin
                  h_sel_nx      = output_h;
                  settle_cnt_nx = '0;
                  state_nx      = SETTLE;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         h_sel      <= '0;
         settle_cnt <= '0;
      end else if (clk_en) begin
         state      <= state_nx;
         h_sel      <= h_sel_nx;
         settle_cnt <= settle_cnt_nx;
      end
   end

   assign cap_tick = clk_en && capture;
   assign cap_idx  = onehot_to_index(h_sel);
   assign seen_cap = seen | (NUM_COMMONS'(1) << cap_idx);

   // Frame bookkeeping. A capture and a pending swap never share a clk because
   // at least two ticks separate consecutive captures.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         seen        <= '0;
         front       <= 1'b0;
         swap_pend   <= 1'b0;
         tmo_cnt     <= '0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         lcd_active  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (swap_pend) begin
            swap_pend   <= 1'b0;
            front       <= ~front;
            seen        <= '0;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 8'd1;
         end
         if (cap_tick) begin
            seen       <= seen_cap;
            tmo_cnt    <= '0;
            lcd_active <= 1'b1;
            if (seen_cap == '1) swap_pend <= 1'b1;
         end else if (clk_en && (tmo_cnt != TMO_MAX)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            // Display declared off: drop the partial frame, keep both banks.
            if (tmo_cnt == TMO_LAST) begin
               lcd_active <= 1'b0;
               seen       <= '0;
            end
         end
      end
   end

   lcd_row_bank u_bank (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (cap_tick),
      .wr_bank  (~front),
      .wr_row   (cap_idx),
      .wr_data  ({segment_bs, segment_b, segment_a}),
      .rd_bank  (front),
      .rd_row   (rd_addr),
      .rd_clear (~lcd_active),
      .rd_data  (rd_data)
   );

endmodule

// File: tb/tb_lcd_segment_capture.sv
// Self-checking bench for lcd_segment_capture. clk_en ticks every second clk.
// Expected frame counts are queued when a frame's last row is driven and
// popped when frame_done is seen; expected read data is queued with each read.
module tb_lcd_segment_capture;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clk_en;
   logic [3:0]  output_h;
   logic [15:0] segment_a;
   logic [15:0] segment_b;
   logic        segment_bs;
   logic [1:0]  rd_addr;
   logic [32:0] rd_data;
   logic        frame_done;
   logic [7:0]  frame_count;
   logic        lcd_active;

   int n_checks = 0;
   int n_errors = 0;
   int fd_cnt   = 0;

   logic [7:0]  fc_q[$];
   logic [32:0] rd_q[$];
   logic [32:0] exp_front [4];
   logic [7:0]  exp_count;

   always #5 clk = ~clk;

   lcd_segment_capture #(
      .SETTLE_TICKS  (2),
      .TIMEOUT_TICKS (2048)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .clk_en      (clk_en),
      .output_h    (output_h),
      .segment_a   (segment_a),
      .segment_b   (segment_b),
      .segment_bs  (segment_bs),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .frame_done  (frame_done),
      .frame_count (frame_count),
      .lcd_active  (lcd_active)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // frame_done monitor: every pulse must match a queued frame
   always @(negedge clk) begin
      if (reset_n === 1'b1 && frame_done === 1'b1) begin
         fd_cnt++;
         chk("frame_expected", 64'(fc_q.size() != 0), 64'd1);
         if (fc_q.size() != 0) chk("frame_count_at_done", 64'(frame_count), 64'(fc_q.pop_front()));
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [32:0] row_val(input int f, input int i);
      logic [15:0] a;
      logic        bs;
      a  = 16'((32'h000F * (i + 1)) ^ (f << 8));
      bs = i[0];
      return {bs, ~a, a};
   endfunction

   task automatic do_tick();
      @(negedge clk); clk_en = 1'b1;
      @(negedge clk); clk_en = 1'b0;
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) do_tick();
   endtask

   task automatic drive_row(input int f, input int i, input int nticks);
      {segment_bs, segment_b, segment_a} = row_val(f, i);
      output_h = 4'(1 << i);
      idle_ticks(nticks);
   endtask

   task automatic read_chk(input string tag, input logic [1:0] addr, input logic [32:0] exp);
      @(negedge clk); rd_addr = addr; rd_q.push_back(exp);
      @(negedge clk); chk(tag, 64'(rd_data), 64'(rd_q.pop_front()));
   endtask

   // Full frame; the read address is held across the swap clk to check that
   // the swap-cycle read returns the previous front bank.
   task automatic send_frame(input int f);
      logic [1:0] sel;
      sel = 2'(f);
      for (int i = 0; i < 3; i++) drive_row(f, i, 4);
      exp_count = exp_count + 8'd1;
      fc_q.push_back(exp_count);
      rd_addr = sel;
      drive_row(f, 3, 4);
      output_h = 4'b0000;
      @(negedge clk);
      chk("swap_read_old", 64'(rd_data), 64'(exp_front[sel]));
      for (int i = 0; i < 4; i++) exp_front[i] = row_val(f, i);
      @(negedge clk);
      chk("swap_read_new", 64'(rd_data), 64'(exp_front[sel]));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rd_data"},     64'(rd_data),     64'd0);
      chk({tag, "_frame_done"},  64'(frame_done),  64'd0);
      chk({tag, "_frame_count"}, 64'(frame_count), 64'd0);
      chk({tag, "_lcd_active"},  64'(lcd_active),  64'd0);
   endtask

   initial begin
      reset_n    = 1'b0;
      clk_en     = 1'b0;
      output_h   = 4'b0000;
      segment_a  = '0;
      segment_b  = '0;
      segment_bs = 1'b0;
      rd_addr    = 2'd0;
      exp_count  = 8'd0;
      for (int i = 0; i < 4; i++) exp_front[i] = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      idle_ticks(2);

      // First frame
      send_frame(0);
      chk("fd_after_frame0", 64'(fd_cnt), 64'd1);
      chk("count_after_frame0", 64'(frame_count), 64'd1);
      chk("active_after_frame0", 64'(lcd_active), 64'd1);
      read_chk("row2_frame0", 2'd2, {1'b0, ~16'h002D, 16'h002D});
      read_chk("row0_frame0", 2'd0, exp_front[0]);

      // Common held too briefly: no capture
      output_h = 4'b0001;
      {segment_bs, segment_b, segment_a} = row_val(9, 0);
      do_tick();
      output_h = 4'b0000;
      idle_ticks(6);
      read_chk("row0_after_glitch", 2'd0, exp_front[0]);
      chk("count_after_glitch", 64'(frame_count), 64'd1);

      // Multi-hot never captures; then a 3-tick strobe on common 2 does
      output_h = 4'b0011;
      idle_ticks(10);
      {segment_bs, segment_b, segment_a} = row_val(7, 2);
      output_h = 4'b0100;
      idle_ticks(3);
      output_h = 4'b0000;
      idle_ticks(4);
      chk("fd_after_row2_only", 64'(fd_cnt), 64'd1);

      // Rows 1 and 3 complete three rows but not row 0
      drive_row(7, 1, 4);
      drive_row(7, 3, 4);
      output_h = 4'b0000;
      idle_ticks(4);
      chk("fd_partial_frame", 64'(fd_cnt), 64'd1);

      // Strobes stop: active until the timeout expires, then reads go to zero
      idle_ticks(2000);
      chk("active_before_timeout", 64'(lcd_active), 64'd1);
      idle_ticks(100);
      chk("active_after_timeout", 64'(lcd_active), 64'd0);
      read_chk("rd_zero_after_timeout_r0", 2'd0, 33'd0);
      read_chk("rd_zero_after_timeout_r3", 2'd3, 33'd0);

      // Full frame after timeout: partial frame discarded, one pulse after row 3
      send_frame(1);
      chk("active_after_restart", 64'(lcd_active), 64'd1);
      chk("fd_after_restart", 64'(fd_cnt), 64'd2);
      read_chk("row1_restart", 2'd1, exp_front[1]);

      // Run until frame_count wraps back to zero
      for (int f = 2; f < 256; f++) send_frame(f);
      chk("count_wrap", 64'(frame_count), 64'd0);
      chk("fd_total", 64'(fd_cnt), 64'd256);
      read_chk("row3_last", 2'd3, exp_front[3]);

      // Reset while settling discards everything
      output_h = 4'b0001;
      {segment_bs, segment_b, segment_a} = row_val(300, 0);
      do_tick();
      @(negedge clk);
      reset_n  = 1'b0;
      output_h = 4'b0000;
      @(negedge clk);
      reset_n = 1'b1;
      check_reset_outputs("midreset");
      exp_count = 8'd0;
      for (int i = 0; i < 4; i++) exp_front[i] = '0;
      idle_ticks(2);
      send_frame(256);
      chk("count_after_midreset", 64'(frame_count), 64'd1);
      read_chk("row0_after_midreset", 2'd0, exp_front[0]);

      idle_ticks(4);
      chk("frames_outstanding", 64'(fc_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
